// File: rtl/gemm_tiled_controller.sv
// Loop controller for the tiled GeMM datapath: walks output tiles, sequences K beats, hands off results.
// Optional GEMM_CTRL_TAIL_MASK_EN: ceil tile counts plus per-beat thermometer lane masks.
module gemm_tiled_controller #(
    parameter int AddrWidth = 16,
    parameter int TileM     = 4,
    parameter int TileK     = 4,
    parameter int TileN     = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 start_i,
    input  logic                 abort_i,
    input  logic                 loop_order_i,
    input  logic [AddrWidth-1:0] M_size_i,
    input  logic [AddrWidth-1:0] K_size_i,
    input  logic [AddrWidth-1:0] N_size_i,
    input  logic                 input_valid_i,
    output logic                 input_ready_o,
    output logic                 acc_clear_o,
    output logic [AddrWidth-1:0] M_count_o,
    output logic [AddrWidth-1:0] K_count_o,
    output logic [AddrWidth-1:0] N_count_o,
`ifdef GEMM_CTRL_TAIL_MASK_EN
    output logic [TileM-1:0]     M_mask_o,
    output logic [TileK-1:0]     K_mask_o,
    output logic [TileN-1:0]     N_mask_o,
`endif
    output logic                 result_valid_o,
    input  logic                 result_ready_i,
    output logic [AddrWidth-1:0] result_m_o,
    output logic [AddrWidth-1:0] result_n_o,
    output logic                 busy_o,
    output logic                 done_o
);

    localparam int LogM = $clog2(TileM);
    localparam int LogK = $clog2(TileK);
    localparam int LogN = $clog2(TileN);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, DONE} state_t;

    state_t state, state_next;

    logic [AddrWidth-1:0] m_sz, k_sz, n_sz;
    logic                 order;
    logic [AddrWidth-1:0] tm, tk, tn;
    logic                 zero_in, stall, accept, res_hs;
    logic                 last_m, last_k, last_n, final_beat;

    function automatic logic [AddrWidth-1:0] tiles(input logic [AddrWidth-1:0] sz, input int lg);
`ifdef GEMM_CTRL_TAIL_MASK_EN
        logic [AddrWidth:0] padded;
        padded = {1'b0, sz} + (AddrWidth+1)'((1 << lg) - 1);
        return AddrWidth'(padded >> lg);
`else
        return sz >> lg;
`endif
    endfunction

    assign tm = tiles(m_sz, LogM);
    assign tk = tiles(k_sz, LogK);
    assign tn = tiles(n_sz, LogN);

    assign zero_in = (tiles(M_size_i, LogM) == '0) || (tiles(K_size_i, LogK) == '0) ||
                     (tiles(N_size_i, LogN) == '0);

    assign stall         = result_valid_o && !result_ready_i;
    assign input_ready_o = (state == BUSY) && !stall;
    assign accept        = input_valid_i && input_ready_o;
    assign acc_clear_o   = (K_count_o == '0) && input_ready_o;
    assign res_hs        = result_valid_o && result_ready_i;
    assign busy_o        = (state != IDLE);

    assign last_m     = (M_count_o == tm - AddrWidth'(1));
    assign last_k     = (K_count_o == tk - AddrWidth'(1));
    assign last_n     = (N_count_o == tn - AddrWidth'(1));
    assign final_beat = last_k && last_m && last_n;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        done_o     = 1'b0;
        case (state)
            IDLE:  if (start_i) state_next = zero_in ? DONE : BUSY;
            BUSY:  if (accept && final_beat) state_next = DRAIN;
            DRAIN: if (res_hs) state_next = DONE;
            DONE: begin
                done_o     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (abort_i) begin
            state_next = IDLE;
            done_o     = 1'b0;
        end
    end

    // Sizes and order are frozen for the whole job; later input changes are ignored.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            m_sz  <= '0;
            k_sz  <= '0;
            n_sz  <= '0;
            order <= 1'b0;
        end else if (state == IDLE && start_i && !abort_i) begin
            m_sz  <= M_size_i;
            k_sz  <= K_size_i;
            n_sz  <= N_size_i;
            order <= loop_order_i;
        end
    end

    // Counters hold on the final beat so DRAIN still shows the last tile position.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            M_count_o <= '0;
            K_count_o <= '0;
            N_count_o <= '0;
        end else if (abort_i || state == DONE || (state == IDLE && start_i)) begin
            M_count_o <= '0;
            K_count_o <= '0;
            N_count_o <= '0;
        end else if (accept && !final_beat) begin
            K_count_o <= last_k ? '0 : K_count_o + AddrWidth'(1);
            if (last_k) begin
                if (!order) begin
                    N_count_o <= last_n ? '0 : N_count_o + AddrWidth'(1);
                    if (last_n) M_count_o <= M_count_o + AddrWidth'(1);
                end else begin
                    M_count_o <= last_m ? '0 : M_count_o + AddrWidth'(1);
                    if (last_m) N_count_o <= N_count_o + AddrWidth'(1);
                end
            end
        end
    end

    // A newly completed tile overrides a same-cycle handshake of the previous one.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            result_valid_o <= 1'b0;
            result_m_o     <= '0;
            result_n_o     <= '0;
        end else if (abort_i) begin
            result_valid_o <= 1'b0;
            result_m_o     <= '0;
            result_n_o     <= '0;
        end else if (accept && last_k) begin
            result_valid_o <= 1'b1;
            result_m_o     <= M_count_o;
            result_n_o     <= N_count_o;
        end else if (res_hs) begin
            result_valid_o <= 1'b0;
        end
    end

`ifdef GEMM_CTRL_TAIL_MASK_EN
    logic [AddrWidth-1:0] m_rem, k_rem, n_rem;
    logic                 m_tail, k_tail, n_tail;

    assign m_rem  = m_sz & AddrWidth'(TileM - 1);
    assign k_rem  = k_sz & AddrWidth'(TileK - 1);
    assign n_rem  = n_sz & AddrWidth'(TileN - 1);
    assign m_tail = last_m && (m_rem != '0);
    assign k_tail = last_k && (k_rem != '0);
    assign n_tail = last_n && (n_rem != '0);

    always_comb begin
        M_mask_o = '0;
        K_mask_o = '0;
        N_mask_o = '0;
        for (int i = 0; i < TileM; i++) M_mask_o[i] = !m_tail || (AddrWidth'(i) < m_rem);
        for (int i = 0; i < TileK; i++) K_mask_o[i] = !k_tail || (AddrWidth'(i) < k_rem);
        for (int i = 0; i < TileN; i++) N_mask_o[i] = !n_tail || (AddrWidth'(i) < n_rem);
    end
`endif

endmodule

// File: tb/tb_gemm_tiled_controller.sv
// Bench for gemm_tiled_controller: expected beat/result streams come from plain nested tile loops.
module tb_gemm_tiled_controller;

    localparam int AW = 16;
    localparam int TM = 4;
    localparam int TK = 4;
    localparam int TN = 4;

    logic          clk = 1'b0;
    logic          rst, start, abort, loop_order;
    logic [AW-1:0] M_size, K_size, N_size;
    logic          input_valid, input_ready, acc_clear;
    logic [AW-1:0] M_count, K_count, N_count;
    logic          result_valid, result_ready;
    logic [AW-1:0] result_m, result_n;
    logic          busy, done;
`ifdef GEMM_CTRL_TAIL_MASK_EN
    logic [TM-1:0] M_mask;
    logic [TK-1:0] K_mask;
    logic [TN-1:0] N_mask;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct { int k; int m; int n; } beat_t;
    typedef struct { int m; int n; } res_t;

    gemm_tiled_controller #(.AddrWidth(AW), .TileM(TM), .TileK(TK), .TileN(TN)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort), .loop_order_i(loop_order),
        .M_size_i(M_size), .K_size_i(K_size), .N_size_i(N_size),
        .input_valid_i(input_valid), .input_ready_o(input_ready), .acc_clear_o(acc_clear),
        .M_count_o(M_count), .K_count_o(K_count), .N_count_o(N_count),
`ifdef GEMM_CTRL_TAIL_MASK_EN
        .M_mask_o(M_mask), .K_mask_o(K_mask), .N_mask_o(N_mask),
`endif
        .result_valid_o(result_valid), .result_ready_i(result_ready),
        .result_m_o(result_m), .result_n_o(result_n), .busy_o(busy), .done_o(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int tiles_of(input int sz, input int t);
`ifdef GEMM_CTRL_TAIL_MASK_EN
        return (sz + t - 1) / t;
`else
        return sz / t;
`endif
    endfunction

    function automatic int therm(input int sz, input int idx, input int t);
        int lanes;
        lanes = sz - idx * t;
        if (lanes >= t) return (1 << t) - 1;
        return (1 << lanes) - 1;
    endfunction

    task automatic start_job(input int M, input int K, input int N, input bit ord);
        start = 1'b1;
        M_size = AW'(M); K_size = AW'(K); N_size = AW'(N);
        loop_order = ord;
        input_valid = 1'b0;
        result_ready = 1'b1;
        step();
        start = 1'b0;
        M_size = AW'($urandom); K_size = AW'($urandom); N_size = AW'($urandom);
        loop_order = ~ord;
    endtask

    // mode 0: always valid/ready; 1: random valid/ready/start noise; 2: ready low 5 cycles after first result
    task automatic run_job(input int M, input int K, input int N, input bit ord, input int mode);
        beat_t bq[$];
        res_t  rq[$];
        beat_t b;
        res_t  r;
        int tm, tk, tn, hold, cyc, om, im;
        bit seen, prev_stall, prev_last;
        logic [AW-1:0] pk, pm, pn, prm, prn, lm, ln;
        tm = tiles_of(M, TM); tk = tiles_of(K, TK); tn = tiles_of(N, TN);
        if (tm > 0 && tk > 0 && tn > 0) begin
            om = ord ? tn : tm;
            im = ord ? tm : tn;
            for (int o = 0; o < om; o++)
                for (int i = 0; i < im; i++) begin
                    for (int k = 0; k < tk; k++)
                        bq.push_back('{k, ord ? i : o, ord ? o : i});
                    rq.push_back('{ord ? i : o, ord ? o : i});
                end
        end
        start_job(M, K, N, ord);
        hold = 0; seen = 0; prev_stall = 0; prev_last = 0; cyc = 0;
        pk = '0; pm = '0; pn = '0; prm = '0; prn = '0; lm = '0; ln = '0;
        while ((bq.size() > 0 || rq.size() > 0) && cyc < 3000) begin
            cyc++;
            if (mode == 1) begin
                input_valid  = ($urandom % 4) != 0;
                result_ready = ($urandom % 3) != 0;
                start        = ($urandom % 4) == 0;
            end else if (mode == 2) begin
                input_valid = 1'b1;
                if (!seen && result_valid) begin seen = 1; hold = 5; end
                result_ready = (hold == 0);
                if (hold > 0) hold--;
            end else begin
                input_valid  = 1'b1;
                result_ready = 1'b1;
            end
            #2;
            chk("no_early_done", done, 0);
            chk("busy_running", busy, 1);
            if (prev_last) begin
                chk("res_latency_valid", result_valid, 1);
                chk("res_latency_m", result_m, lm);
                chk("res_latency_n", result_n, ln);
            end
            if (prev_stall) begin
                chk("stall_k_frozen", K_count, pk);
                chk("stall_m_frozen", M_count, pm);
                chk("stall_n_frozen", N_count, pn);
                chk("stall_res_m", result_m, prm);
                chk("stall_res_n", result_n, prn);
                chk("stall_res_valid", result_valid, 1);
            end
            if (result_valid && !result_ready) chk("stall_no_ready", input_ready, 0);
            if (!input_ready) chk("no_clear_idle", acc_clear, 0);
            if (input_ready) chk("ready_needs_beat", bq.size() > 0, 1);
            prev_last = 0;
            if (input_valid && input_ready && bq.size() > 0) begin
                b = bq.pop_front();
                chk("beat_k", K_count, b.k);
                chk("beat_m", M_count, b.m);
                chk("beat_n", N_count, b.n);
                chk("beat_clear", acc_clear, b.k == 0);
`ifdef GEMM_CTRL_TAIL_MASK_EN
                chk("beat_m_mask", M_mask, therm(M, b.m, TM));
                chk("beat_k_mask", K_mask, therm(K, b.k, TK));
                chk("beat_n_mask", N_mask, therm(N, b.n, TN));
`endif
                if (b.k == tk - 1) begin
                    prev_last = 1;
                    lm = AW'(b.m);
                    ln = AW'(b.n);
                end
            end
            if (result_valid && result_ready) begin
                chk("result_expected", rq.size() > 0, 1);
                if (rq.size() > 0) begin
                    r = rq.pop_front();
                    chk("result_m", result_m, r.m);
                    chk("result_n", result_n, r.n);
                end
            end
            prev_stall = result_valid && !result_ready;
            pk = K_count; pm = M_count; pn = N_count; prm = result_m; prn = result_n;
            step();
        end
        start = 1'b0; input_valid = 1'b0; result_ready = 1'b1;
        chk("queues_drained", bq.size() + rq.size(), 0);
        #2;
        chk("done_pulse", done, 1);
        chk("done_no_input", input_ready, 0);
        chk("done_no_result", result_valid, 0);
        step();
        #2;
        chk("done_one_cycle", done, 0);
        chk("idle_after_done", busy, 0);
        chk("idle_counters", {K_count, M_count}, 0);
        step();
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; loop_order = 1'b0;
        M_size = '0; K_size = '0; N_size = '0;
        input_valid = 1'b0; result_ready = 1'b0;
        #3;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", input_ready, 0);
        chk("rst_clear", acc_clear, 0);
        chk("rst_res_valid", result_valid, 0);
        chk("rst_counts", {M_count, K_count}, 0);
        chk("rst_n_count", N_count, 0);
        chk("rst_res_mn", {result_m, result_n}, 0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        step();

        run_job(8, 8, 8, 0, 0);
        run_job(8, 8, 8, 1, 0);
        run_job(4, 4, 4, 0, 2);
        run_job(4, 4, 8, 0, 2);
        run_job(8, 0, 8, 0, 0);
        run_job(3, 8, 8, 0, 0);
        run_job(8, 4, 12, 1, 2);
`ifdef GEMM_CTRL_TAIL_MASK_EN
        run_job(6, 5, 4, 0, 0);
        run_job(10, 3, 7, 1, 1);
`endif

        // abort presented alongside the fourth beat
        start_job(8, 8, 8, 0);
        input_valid = 1'b1; result_ready = 1'b1;
        repeat (3) step();
        abort = 1'b1;
        step();
        abort = 1'b0; input_valid = 1'b0;
        #2;
        chk("abort_idle", busy, 0);
        chk("abort_counts", {M_count, K_count}, 0);
        chk("abort_n_count", N_count, 0);
        chk("abort_res_valid", result_valid, 0);
        chk("abort_no_done", done, 0);
        chk("abort_no_ready", input_ready, 0);
        step(); #2;
        chk("abort_no_done_late", done, 0);
        step();

        // asynchronous reset between clock edges
        start_job(8, 8, 8, 0);
        input_valid = 1'b1; result_ready = 1'b0;
        repeat (3) step();
        #3;
        rst = 1'b1;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_counts", {M_count, K_count}, 0);
        chk("arst_res_valid", result_valid, 0);
        chk("arst_res_mn", {result_m, result_n}, 0);
        chk("arst_ready", input_ready, 0);
        step();
        rst = 1'b0; input_valid = 1'b0; result_ready = 1'b1;
        step();

        for (int j = 0; j < 20; j++)
            run_job($urandom_range(0, 14), $urandom_range(0, 14), $urandom_range(0, 14),
                    1'($urandom % 2), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
